ramp_capture_ctrl: RTL and testbench

// - Parametrised successor to the 8-bit ramp/R2R sample capture stage in the discrete ADC.
// - Synchronises the LM311 comparator and qualifies crossings against a ramp window.
// - Captures the ramp code once per sweep, flags sweeps with no crossing as overrange,
//   and optionally averages 2^AVG_LOG2 conversions.
// - Sits between the ramp/R2R generator and the downstream data formatter/UART path.

---
 rtl/ramp_capture_ctrl_if.sv | 21 ++
 rtl/ramp_capture_ctrl.sv | 137 +++++++++++++
 tb/tb_ramp_capture_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/ramp_capture_ctrl_if.sv
// ramp_capture_ctrl_if: ramp/comparator inputs and capture/average outputs of the ramp capture stage
interface ramp_capture_ctrl_if #(parameter int WIDTH = 8);
  logic             compare_match;
  logic             ramp_start;
  logic             ramp_end;
  logic [WIDTH-1:0] ramp_value;
  logic [WIDTH-1:0] raw_data;
  logic             overrange;
  logic             ready_pulse;
  logic [WIDTH-1:0] avg_data;
  logic             avg_valid;
  logic             avg_overrange;
  modport master (
    output compare_match, ramp_start, ramp_end, ramp_value,
    input  raw_data, overrange, ready_pulse, avg_data, avg_valid, avg_overrange
  );
  modport slave (
    input  compare_match, ramp_start, ramp_end, ramp_value,
    output raw_data, overrange, ready_pulse, avg_data, avg_valid, avg_overrange
  );
endinterface

// File: rtl/ramp_capture_ctrl.sv
// ramp_capture_ctrl: synchronised comparator capture of the ramp code, once per sweep, with overrange flag.
// Define SAMPLE_AVG_EN to average 2^AVG_LOG2 captures; otherwise avg_* mirror the raw outputs.
module ramp_capture_ctrl #(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int ACTIVE_LOW     = 1,
  parameter int CAPTURE_OFFSET = 0,
  parameter int AVG_LOG2       = 2
) (
  input logic clk,
  input logic reset,
  ramp_capture_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURED} state_t;
  localparam logic INACT = (ACTIVE_LOW != 0);
  localparam logic [WIDTH:0] OFFSET = CAPTURE_OFFSET[WIDTH:0];
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (AVG_LOG2 < 1 || AVG_LOG2 > 8) begin : g_bad_avg
    $error("AVG_LOG2 must be in 1..8");
  end
  if (CAPTURE_OFFSET < 0 || CAPTURE_OFFSET >= (1 << WIDTH)) begin : g_bad_off
    $error("CAPTURE_OFFSET must be below 2^WIDTH");
  end
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       raw_q, raw_d;
  logic                   ovr_q, ovr_d;
  logic                   ready_q, ready_d;
  logic [WIDTH:0]         diff;
  logic                   evt;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.compare_match};
    prev_d = sync_q[SYNC_STAGES-1];
    evt = (sync_q[SYNC_STAGES-1] != INACT) && (prev_q == INACT);
    diff = {1'b0, bus.ramp_value} - OFFSET;
  end
  // ramp_start always re-arms and swallows a coincident event; CAPTURED ignores chatter
  always_comb begin
    state_d = state_q;
    raw_d   = raw_q;
    ovr_d   = ovr_q;
    ready_d = 1'b0;
    if (bus.ramp_start) begin
      state_d = ARMED;
    end else if (state_q == ARMED && evt) begin
      raw_d   = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
      ovr_d   = 1'b0;
      ready_d = 1'b1;
      state_d = bus.ramp_end ? IDLE : CAPTURED;
    end else if (state_q == ARMED && bus.ramp_end) begin
      raw_d   = '1;
      ovr_d   = 1'b1;
      ready_d = 1'b1;
      state_d = IDLE;
    end else if (state_q == CAPTURED && bus.ramp_end) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{INACT}};
      prev_q  <= INACT;
      state_q <= IDLE;
      raw_q   <= '0;
      ovr_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      raw_q   <= raw_d;
      ovr_q   <= ovr_d;
      ready_q <= ready_d;
    end
  end
  assign bus.raw_data    = raw_q;
  assign bus.overrange   = ovr_q;
  assign bus.ready_pulse = ready_q;
`ifdef SAMPLE_AVG_EN
  localparam int AW = WIDTH + AVG_LOG2;
  logic [AW-1:0]       acc_q, acc_d, acc_sum;
  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic                aor_q, aor_d;
  logic [WIDTH-1:0]    avg_q, avg_d;
  logic                avgv_q, avgv_d;
  logic                avgo_q, avgo_d;
  // overrange samples already hold all ones in raw_q, so they accumulate as full scale
  always_comb begin
    acc_sum = acc_q + AW'(raw_q);
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    aor_d   = aor_q;
    avg_d   = avg_q;
    avgv_d  = 1'b0;
    avgo_d  = avgo_q;
    if (ready_q && &cnt_q) begin
      avg_d  = acc_sum[AW-1:AVG_LOG2];
      avgv_d = 1'b1;
      avgo_d = aor_q | ovr_q;
      acc_d  = '0;
      cnt_d  = '0;
      aor_d  = 1'b0;
    end else if (ready_q) begin
      acc_d = acc_sum;
      cnt_d = cnt_q + AVG_LOG2'(1);
      aor_d = aor_q | ovr_q;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      aor_q  <= 1'b0;
      avg_q  <= '0;
      avgv_q <= 1'b0;
      avgo_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      aor_q  <= aor_d;
      avg_q  <= avg_d;
      avgv_q <= avgv_d;
      avgo_q <= avgo_d;
    end
  end
  assign bus.avg_data      = avg_q;
  assign bus.avg_valid     = avgv_q;
  assign bus.avg_overrange = avgo_q;
`else
  assign bus.avg_data      = raw_q;
  assign bus.avg_valid     = ready_q;
  assign bus.avg_overrange = ovr_q;
`endif
endmodule

// File: tb/tb_ramp_capture_ctrl.sv
// tb_ramp_capture_ctrl: scoreboard bench driving a zero-offset and an offset-3 instance with shared ramp stimulus
module tb_ramp_capture_ctrl;
  typedef struct packed {
    logic [7:0] raw;
    logic       ovr;
  } exp_t;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cm = 1'b1;
  logic       rs = 1'b0;
  logic       re = 1'b0;
  logic [7:0] rv = 8'h00;
  int         total = 0;
  int         passed = 0;
  logic       prdy0 = 1'b0;
  logic       prdy1 = 1'b0;
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       qa0[$];
  exp_t       qa1[$];
  always #5 clk = ~clk;
  ramp_capture_ctrl_if #(.WIDTH(8)) b0();
  ramp_capture_ctrl_if #(.WIDTH(8)) b1();
  assign b0.compare_match = cm;
  assign b0.ramp_start    = rs;
  assign b0.ramp_end      = re;
  assign b0.ramp_value    = rv;
  assign b1.compare_match = cm;
  assign b1.ramp_start    = rs;
  assign b1.ramp_end      = re;
  assign b1.ramp_value    = rv;
  ramp_capture_ctrl #(.WIDTH(8)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
  ramp_capture_ctrl #(.WIDTH(8), .CAPTURE_OFFSET(3)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  task automatic chk(input string n, input int id, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s dut%0d got=%0h want=%0h", n, id, a, e);
  endtask
  task automatic mon(input int id, input logic [7:0] raw, input logic ovr, input logic rdy,
                     input logic [7:0] ad, input logic av, input logic ao);
    exp_t e;
    if (rdy) begin
      if ((id == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
        total++;
        $display("FAIL unexpected_ready_pulse dut%0d got raw=%0h ovr=%0b want no pulse", id, raw, ovr);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk("raw_data", id, 32'(raw), 32'(e.raw));
        chk("overrange", id, 32'(ovr), 32'(e.ovr));
      end
    end
`ifdef SAMPLE_AVG_EN
    if (av) begin
      chk("avg_trails_ready", id, 32'((id == 0) ? prdy0 : prdy1), 32'd1);
      if ((id == 0) ? (qa0.size() == 0) : (qa1.size() == 0)) begin
        total++;
        $display("FAIL unexpected_avg_valid dut%0d got avg=%0h want no pulse", id, ad);
      end else begin
        e = (id == 0) ? qa0.pop_front() : qa1.pop_front();
        chk("avg_data", id, 32'(ad), 32'(e.raw));
        chk("avg_overrange", id, 32'(ao), 32'(e.ovr));
      end
    end
`else
    if (rdy || av) begin
      chk("avg_valid_mirror", id, 32'(av), 32'(rdy));
      chk("avg_data_mirror", id, 32'(ad), 32'(raw));
      chk("avg_ovr_mirror", id, 32'(ao), 32'(ovr));
    end
`endif
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      mon(0, b0.raw_data, b0.overrange, b0.ready_pulse, b0.avg_data, b0.avg_valid, b0.avg_overrange);
      mon(1, b1.raw_data, b1.overrange, b1.ready_pulse, b1.avg_data, b1.avg_valid, b1.avg_overrange);
      prdy0 = b0.ready_pulse;
      prdy1 = b1.ready_pulse;
    end
  end
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_start();
    rs = 1'b1;
    tick();
    rs = 1'b0;
  endtask
  task automatic pulse_end();
    re = 1'b1;
    tick();
    re = 1'b0;
  endtask
  task automatic expect2(input logic [7:0] a, input logic oa, input logic [7:0] b, input logic ob);
    q0.push_back({a, oa});
    q1.push_back({b, ob});
  endtask
  // drops the comparator and returns inside the cycle where the synchronised event is seen
  task automatic fall_to_event();
    cm = 1'b0;
    tick(2);
  endtask
  task automatic capture(input logic [7:0] v, input logic [7:0] v_off);
    rv = v;
    pulse_start();
    expect2(v, 1'b0, v_off, 1'b0);
    fall_to_event();
    tick();
    pulse_end();
    cm = 1'b1;
    tick(3);
  endtask
  initial begin
    tick(2);
    chk("reset_raw", 0, 32'(b0.raw_data), 32'h0);
    chk("reset_ovr", 0, 32'(b0.overrange), 32'h0);
    chk("reset_ready", 0, 32'(b0.ready_pulse), 32'h0);
    chk("reset_avg_valid", 0, 32'(b0.avg_valid), 32'h0);
    reset = 1'b0;
    tick(2);
    rv = 8'h5A;
    pulse_start();
    expect2(8'h5A, 1'b0, 8'h57, 1'b0);
    fall_to_event();
    chk("ready_not_early", 0, 32'(b0.ready_pulse), 32'h0);
    tick();
    chk("ready_3_cycles", 0, 32'(b0.ready_pulse), 32'h1);
    tick();
    chk("ready_one_cycle", 0, 32'(b0.ready_pulse), 32'h0);
    cm = 1'b1; tick(3);
    cm = 1'b0; tick(3);
    cm = 1'b1; tick(3);
    cm = 1'b0; tick(4);
    pulse_end();
    tick(2);
    chk("chatter_hold_raw", 0, 32'(b0.raw_data), 32'h5A);
    cm = 1'b1;
    tick(3);
    rv = 8'h77;
    pulse_start();
    tick(3);
    expect2(8'hFF, 1'b1, 8'hFF, 1'b1);
    pulse_end();
    tick(3);
    pulse_end();
    tick(3);
    pulse_start();
    tick(2);
    reset = 1'b1;
    #1;
    chk("abort_raw", 0, 32'(b0.raw_data), 32'h0);
    chk("abort_ovr", 0, 32'(b0.overrange), 32'h0);
    chk("abort_ready", 0, 32'(b0.ready_pulse), 32'h0);
    chk("abort_raw", 1, 32'(b1.raw_data), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(2);
    cm = 1'b0;
    tick(6);
    cm = 1'b1;
    tick(4);
`ifdef SAMPLE_AVG_EN
    qa0.push_back({8'h51, 1'b1});
    qa0.push_back({8'h28, 1'b0});
    qa1.push_back({8'h4F, 1'b1});
    qa1.push_back({8'h25, 1'b0});
`endif
    capture(8'h02, 8'h00);
    capture(8'h10, 8'h0D);
    rv = 8'h20;
    pulse_start();
    tick();
    fall_to_event();
    pulse_start();
    tick(3);
    expect2(8'hFF, 1'b1, 8'hFF, 1'b1);
    pulse_end();
    cm = 1'b1;
    tick(3);
    rv = 8'h33;
    pulse_start();
    expect2(8'h33, 1'b0, 8'h30, 1'b0);
    fall_to_event();
    pulse_end();
    tick(2);
    pulse_end();
    cm = 1'b1;
    tick(3);
    capture(8'h10, 8'h0D);
    capture(8'h20, 8'h1D);
    capture(8'h30, 8'h2D);
    capture(8'h41, 8'h3E);
    tick(5);
    chk("pending_pulses", 0, 32'(q0.size()), 32'd0);
    chk("pending_pulses", 1, 32'(q1.size()), 32'd0);
    chk("pending_avgs", 0, 32'(qa0.size()), 32'd0);
    chk("pending_avgs", 1, 32'(qa1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
